// File: rtl/seq_decoder.sv
// Registered N-to-2**N decoder with direct, thermometer and up/down scan modes.
// The scan counter wraps modulo 2**N and flags each wrap with a one-cycle pulse.
module seq_decoder #(
  parameter int unsigned N       = 3,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [N-1:0]        a,
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int unsigned W = 1 << N;
  localparam logic [W-1:0] YMask = ACT_LOW ? {W{1'b1}} : {W{1'b0}};
  localparam logic [N-1:0] CntMax = {N{1'b1}};

  typedef enum logic [1:0] {
    ModeDirect   = 2'b00,
    ModeScanUp   = 2'b01,
    ModeScanDown = 2'b10,
    ModeTherm    = 2'b11
  } mode_e;

  logic [N-1:0] cnt_q, cnt_d;
  logic [W-1:0] y_q, y_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] therm;

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < W; i++) begin
      therm[i] = (N'(i) <= a);
    end
  end

  // y_d is the active-high pattern; polarity is applied only when it is registered.
  always_comb begin
    cnt_d  = cnt_q;
    y_d    = y_q ^ YMask;
    wrap_d = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        ModeDirect: begin
          cnt_d = a;
          y_d   = W'(1) << a;
        end
        ModeTherm: begin
          cnt_d = a;
          y_d   = therm;
        end
        ModeScanUp: begin
          if (load) begin
            cnt_d = a;
          end else begin
            cnt_d  = cnt_q + N'(1);
            wrap_d = (cnt_q == CntMax);
          end
          y_d = W'(1) << cnt_d;
        end
        ModeScanDown: begin
          if (load) begin
            cnt_d = a;
          end else begin
            cnt_d  = cnt_q - N'(1);
            wrap_d = (cnt_q == '0);
          end
          y_d = W'(1) << cnt_d;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      y_q    <= YMask;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      y_q    <= y_d ^ YMask;
      wrap_q <= wrap_d;
    end
  end

  // The index on y is always the counter value, so idx is simply the counter register.
  assign y    = y_q;
  assign idx  = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder: an active-high and an active-low instance share
// identical stimulus, so the active-low y must always be the inverse of the expectation.
module tb_seq_decoder;

  localparam int unsigned N = 3;
  localparam int unsigned W = 1 << N;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [N-1:0] a;
  logic [W-1:0] y0, y1;
  logic [N-1:0] idx0, idx1;
  logic         wrap0, wrap1;

  int checks = 0;
  int errors = 0;

  seq_decoder #(.N(N), .ACT_LOW(1'b0)) u_hi (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .load (load), .a (a),
    .y (y0), .idx (idx0), .wrap (wrap0)
  );

  seq_decoder #(.N(N), .ACT_LOW(1'b1)) u_lo (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .load (load), .a (a),
    .y (y1), .idx (idx1), .wrap (wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] ye, input logic [N-1:0] ie,
                       input logic we);
    logic [W-1:0] yn;
    yn = ~ye;
    checks++;
    assert (y0 === ye) else begin
      errors++;
      $error("FAIL %s y: got %b want %b", tag, y0, ye);
    end
    checks++;
    assert (y1 === yn) else begin
      errors++;
      $error("FAIL %s y_act_low: got %b want %b", tag, y1, yn);
    end
    checks++;
    assert ((idx0 === ie) && (idx1 === ie)) else begin
      errors++;
      $error("FAIL %s idx: got %0d/%0d want %0d", tag, idx0, idx1, ie);
    end
    checks++;
    assert ((wrap0 === we) && (wrap1 === we)) else begin
      errors++;
      $error("FAIL %s wrap: got %b/%b want %b", tag, wrap0, wrap1, we);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; a = '0;
    cyc();
    check("reset", 8'h00, 3'd0, 1'b0);

    // Direct sweep: one-hot of a, one cycle latency.
    rst = 1'b0; en = 1'b1; mode = 2'b00;
    for (int i = 0; i < 8; i++) begin
      a = N'(i);
      cyc();
      check("direct", W'(1) << i, N'(i), 1'b0);
    end

    // Thermometer.
    mode = 2'b11;
    a = 3'd0; cyc(); check("therm0", 8'h01, 3'd0, 1'b0);
    a = 3'd3; cyc(); check("therm3", 8'h0f, 3'd3, 1'b0);
    a = 3'd7; cyc(); check("therm7", 8'hff, 3'd7, 1'b0);
    // load ignored outside scan modes.
    load = 1'b1; a = 3'd5; cyc(); check("therm_load", 8'h3f, 3'd5, 1'b0);
    load = 1'b0;

    // Scan up from reset with an en=0 hold and a hold right after the wrap.
    rst = 1'b1; cyc(); check("reset2", 8'h00, 3'd0, 1'b0);
    rst = 1'b0; mode = 2'b01; a = 3'd6;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check("scan_up", W'(1) << (k % 8), N'(k % 8), (k == 8));
      if (k == 3) begin
        en = 1'b0;
        cyc(); check("hold_a", 8'h08, 3'd3, 1'b0);
        cyc(); check("hold_b", 8'h08, 3'd3, 1'b0);
        en = 1'b1;
      end
      if (k == 8) begin
        en = 1'b0;
        cyc(); check("hold_wrap", 8'h01, 3'd0, 1'b0);
        en = 1'b1;
      end
    end

    // Scan down with load.
    mode = 2'b10; load = 1'b1; a = 3'd2;
    cyc(); check("down_load", 8'h04, 3'd2, 1'b0);
    load = 1'b0;
    cyc(); check("down1", 8'h02, 3'd1, 1'b0);
    cyc(); check("down0", 8'h01, 3'd0, 1'b0);
    cyc(); check("down_wrap", 8'h80, 3'd7, 1'b1);

    // Load beats a pending wrap in scan-up (cnt=7).
    mode = 2'b01; load = 1'b1; a = 3'd4;
    cyc(); check("load_prio", 8'h10, 3'd4, 1'b0);
    load = 1'b0;
    cyc(); check("up5", 8'h20, 3'd5, 1'b0);

    // Mode change continues from the current count.
    mode = 2'b10;
    cyc(); check("mode_sw", 8'h10, 3'd4, 1'b0);
    mode = 2'b01;
    cyc(); check("up5b", 8'h20, 3'd5, 1'b0);

    // Reset mid-scan beats en/load/mode.
    rst = 1'b1; load = 1'b1; a = 3'd3;
    cyc(); check("rst_mid", 8'h00, 3'd0, 1'b0);
    rst = 1'b0; load = 1'b0;
    cyc(); check("after_rst", 8'h02, 3'd1, 1'b0);

    // Scan down immediately after reset wraps to max.
    rst = 1'b1; cyc(); check("reset3", 8'h00, 3'd0, 1'b0);
    rst = 1'b0; mode = 2'b10;
    cyc(); check("down_rst_wrap", 8'h80, 3'd7, 1'b1);
    cyc(); check("down6", 8'h40, 3'd6, 1'b0);

    // Direct clears wrap and tracks a.
    mode = 2'b00; a = 3'd4;
    cyc(); check("direct4", 8'h10, 3'd4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_decoder.md
SEQ_DECODER -- requirements
Module: seq_decoder

Interface
REQ-001 Parameter N, default 3, select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter ACT_LOW, default 0; 1 inverts every bit of y (active-low outputs).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  update enable; when 0, all registers hold.
REQ-006 mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 THERM.
REQ-007 load  input  1  in scan modes, load counter from a.
REQ-008 a  input  N  select / load value.
REQ-009 y  output  2**N  registered decoded output.
REQ-010 idx  output  N  registered index currently driven on y.
REQ-011 wrap  output  1  one-cycle pulse on counter wrap-around.

Function
REQ-012 All outputs SHALL be registered; no combinational path from any input to y, idx or wrap.
REQ-013 Internal counter cnt (N bits) SHALL exist; idx SHALL equal the value decoded into y in the same cycle.
REQ-014 DIRECT: on a clock edge with en=1, y <= one-hot(a) (bit a set only), idx <= a, cnt <= a; latency one cycle.
REQ-015 THERM: on en=1, y <= bits 0..a set, all higher bits clear (a=0 gives only bit 0), idx <= a, cnt <= a.
REQ-016 SCAN_UP: on en=1, load=0, cnt <= cnt+1 modulo 2**N; y <= one-hot(new cnt); idx <= new cnt.
REQ-017 SCAN_DOWN: on en=1, load=0, cnt <= cnt-1 modulo 2**N; y and idx track new cnt as in REQ-016.
REQ-018 In scan modes, load=1 with en=1 SHALL set cnt <= a, y <= one-hot(a), idx <= a, wrap <= 0; load takes priority over counting.
REQ-019 load SHALL be ignored in DIRECT and THERM (those already track a).
REQ-020 wrap SHALL be 1 for exactly the cycle following an edge where cnt went 2**N-1 -> 0 in SCAN_UP or 0 -> 2**N-1 in SCAN_DOWN; 0 in all other cycles, including DIRECT/THERM, load, and en=0.
REQ-021 en=0 SHALL hold y, idx and cnt, and clear wrap.
REQ-022 Mode change takes effect at the next enabled edge; the scan continues from the current cnt (no restart), e.g. SCAN_UP at cnt=5 switched to SCAN_DOWN yields 4.
REQ-023 ACT_LOW=1 SHALL apply only as a final inversion of y; idx, wrap and counting unaffected.
REQ-024 Out-of-range mode encodings do not exist (2-bit field fully decoded); no X propagation from any legal input.

Reset
REQ-025 rst=1 at a clock edge SHALL set cnt=0, idx=0, wrap=0, and y=all zeros (ACT_LOW=0) or all ones (ACT_LOW=1), i.e. all outputs inactive.
REQ-026 rst SHALL take priority over en, load and mode; reset asserted mid-scan aborts the scan immediately; the first enabled edge after release starts from cnt=0 (SCAN_UP gives idx=1, SCAN_DOWN gives idx=2**N-1 with wrap=1).

Verification (N=3, ACT_LOW=0 unless stated)
REQ-027 DIRECT sweep: en=1, a=0..7 one per cycle -> y one cycle later = 00000001, 00000010, ..., 10000000; idx=a; wrap=0 throughout.
REQ-028 SCAN_UP from reset: 9 enabled cycles -> idx 1,2,...,7,0,1; wrap=1 only in the cycle idx=0; en=0 for 2 cycles mid-run holds idx and wrap=0.
REQ-029 SCAN_DOWN with load: load=1, a=2, then 3 cycles -> idx 2,1,0,7; wrap=1 only at idx=7; y=10000000 at that point.
REQ-030 THERM: a=0 -> y=00000001; a=3 -> 00001111; a=7 -> 11111111.
REQ-031 Reset mid-scan: SCAN_UP at idx=5, rst=1 for 1 cycle -> y=00000000, idx=0, wrap=0; next enabled cycle idx=1.
REQ-032 ACT_LOW=1 instance: reset -> y=11111111; DIRECT a=4 -> y=11101111; SCAN_UP wrap timing identical to REQ-028.
